// File: rtl/ysyx_ifu_icache_if.sv
`timescale 1ns/1ps
// ysyx_ifu_icache_if: fetch handshake (upstream/downstream) and refill read channel of the IFU.
// master = the IFU/I-cache view, slave = the environment (PC logic, decode, memory bus).
interface ysyx_ifu_icache_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              prev_valid;
  logic              ready_o;
  logic [ADDR_W-1:0] npc;
  logic              valid_o;
  logic              next_ready;
  logic [DATA_W-1:0] inst_o;
  logic [ADDR_W-1:0] pc_o;
  logic              flush_i;
  logic [ADDR_W-1:0] ifu_araddr_o;
  logic              ifu_arvalid_o;
  logic [7:0]        ifu_arlen_o;
  logic              ifu_arready;
  logic [DATA_W-1:0] ifu_rdata;
  logic              ifu_rvalid;
  logic              ifu_rlast;

  modport master (
    input  prev_valid, npc, next_ready, flush_i,
    input  ifu_arready, ifu_rdata, ifu_rvalid, ifu_rlast,
    output ready_o, valid_o, inst_o, pc_o,
    output ifu_araddr_o, ifu_arvalid_o, ifu_arlen_o
  );

  modport slave (
    output prev_valid, npc, next_ready, flush_i,
    output ifu_arready, ifu_rdata, ifu_rvalid, ifu_rlast,
    input  ready_o, valid_o, inst_o, pc_o,
    input  ifu_araddr_o, ifu_arvalid_o, ifu_arlen_o
  );
endinterface

// File: rtl/ysyx_ifu_icache.sv
`timescale 1ns/1ps
// ysyx_ifu_icache: instruction fetch unit with a set-associative L1 I-cache and burst line refill.
// Define YSYX_ICACHE_PERF_EN to build the hit/miss performance counters (otherwise they read 0).
module ysyx_ifu_icache #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SETS       = 16,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  ysyx_ifu_icache_if.master bus,
  output logic [31:0]       perf_hit_o,
  output logic [31:0]       perf_miss_o
);
  localparam int OFF_W = $clog2(LINE_WORDS) + 2;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int WO_W  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int DEPTH = SETS * LINE_WORDS;
  localparam int DA_W  = $clog2(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_REQ, S_REFILL, S_VALID} state_e;

  state_e                     state_q, state_d;
  logic [ADDR_W-1:0]          fetch_q, fetch_d;
  logic [DATA_W-1:0]          inst_q, inst_d;
  logic [WO_W-1:0]            cnt_q, cnt_d;
  logic                       flush_pend_q, flush_pend_d;
  logic [WAYS-1:0][SETS-1:0]  valid_q, valid_d;
  logic [SETS-1:0][WAY_W-1:0] rr_q, rr_d;

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
    return IDX_W'(a >> OFF_W);
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
    return TAG_W'(a >> (OFF_W + IDX_W));
  endfunction

  function automatic logic [WO_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    return (LINE_WORDS > 1) ? WO_W'(a >> 2) : '0;
  endfunction

  function automatic logic [DA_W-1:0] daddr(input logic [IDX_W-1:0] idx, input logic [WO_W-1:0] w);
    return DA_W'(int'(idx) * LINE_WORDS + int'(w));
  endfunction

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic [WO_W-1:0]  f_word;
  logic [WAY_W-1:0] victim;
  assign f_idx  = idx_of(fetch_q);
  assign f_tag  = tag_of(fetch_q);
  assign f_word = word_of(fetch_q);
  assign victim = rr_q[f_idx];

  // Arrays are read with the incoming npc while idle so LOOKUP sees registered tag/data.
  logic             rd_en;
  logic [IDX_W-1:0] rd_idx;
  logic [DA_W-1:0]  rd_addr;
  logic [DA_W-1:0]  wr_addr;
  logic             data_we;
  logic             tag_we;
  assign rd_en   = (state_q == S_IDLE);
  assign rd_idx  = idx_of(bus.npc);
  assign rd_addr = daddr(rd_idx, word_of(bus.npc));
  assign wr_addr = daddr(f_idx, cnt_q);

  logic [WAYS-1:0]             way_hit;
  logic [WAYS-1:0][DATA_W-1:0] rd_data;

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      logic [DATA_W-1:0] data_mem [DEPTH];
      logic [TAG_W-1:0]  tag_mem  [SETS];
      logic [DATA_W-1:0] data_rd_q;
      logic [TAG_W-1:0]  tag_rd_q;
      logic              sel;

      assign sel = (victim == WAY_W'(gi));

      always_ff @(posedge clk) begin
        if (data_we && sel) data_mem[wr_addr] <= bus.ifu_rdata;
        if (tag_we && sel)  tag_mem[f_idx]    <= f_tag;
        if (rd_en) begin
          data_rd_q <= data_mem[rd_addr];
          tag_rd_q  <= tag_mem[rd_idx];
        end
      end

      assign rd_data[gi] = data_rd_q;
      assign way_hit[gi] = valid_q[gi][f_idx] && (tag_rd_q == f_tag);
    end
  endgenerate

  logic              hit;
  logic [DATA_W-1:0] hit_data;
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) begin
        hit      = 1'b1;
        hit_data = rd_data[w];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_d      = fetch_q;
    inst_d       = inst_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    valid_d      = valid_q;
    rr_d         = rr_q;
    data_we      = 1'b0;
    tag_we       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.prev_valid) begin
          fetch_d = bus.npc;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          inst_d  = hit_data;
          state_d = S_VALID;
        end else begin
          flush_pend_d = 1'b0;
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.ifu_arready) begin
          cnt_d   = '0;
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        if (bus.ifu_rvalid) begin
          data_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == f_word) inst_d = bus.ifu_rdata;
          if (bus.ifu_rlast) begin
            tag_we      = 1'b1;
            rr_d[f_idx] = (victim == WAY_W'(WAYS - 1)) ? '0 : victim + 1'b1;
            if (!flush_pend_q) valid_d[victim][f_idx] = 1'b1;
            state_d = S_VALID;
          end
        end
      end
      S_VALID: begin
        if (bus.next_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Flush overrides any fill completing in the same cycle; an in-flight fill is poisoned.
    if (bus.flush_i) begin
      valid_d = '0;
      if (state_q == S_REQ || state_q == S_REFILL) flush_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fetch_q      <= '0;
      inst_q       <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
      rr_q         <= '0;
    end else begin
      state_q      <= state_d;
      fetch_q      <= fetch_d;
      inst_q       <= inst_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
      rr_q         <= rr_d;
    end
  end

  assign bus.ready_o       = (state_q == S_IDLE);
  assign bus.valid_o       = (state_q == S_VALID);
  assign bus.inst_o        = inst_q;
  assign bus.pc_o          = fetch_q;
  assign bus.ifu_arvalid_o = (state_q == S_REQ);
  assign bus.ifu_araddr_o  = {fetch_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign bus.ifu_arlen_o   = 8'(LINE_WORDS - 1);

`ifdef YSYX_ICACHE_PERF_EN
  logic [31:0] perf_hit_q, perf_hit_d;
  logic [31:0] perf_miss_q, perf_miss_d;
  always_comb begin
    perf_hit_d  = perf_hit_q  + 32'((state_q == S_LOOKUP) &&  hit);
    perf_miss_d = perf_miss_q + 32'((state_q == S_LOOKUP) && !hit);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hit_q  <= '0;
      perf_miss_q <= '0;
    end else begin
      perf_hit_q  <= perf_hit_d;
      perf_miss_q <= perf_miss_d;
    end
  end
  assign perf_hit_o  = perf_hit_q;
  assign perf_miss_o = perf_miss_q;
`else
  assign perf_hit_o  = '0;
  assign perf_miss_o = '0;
`endif
endmodule

// File: tb/tb_ysyx_ifu_icache.sv
`timescale 1ns/1ps
// tb_ysyx_ifu_icache: directed fetch sequences checked every cycle against a line-level cache model
// (line address per way, round-robin victim per set, memory word = ~addr ^ 0x5A5A0000).
module tb_ysyx_ifu_icache;
  localparam int SETS = 16;
  localparam int WAYS = 2;
  localparam int LW   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_ifu_icache_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  logic [31:0] perf_hit, perf_miss;

  ysyx_ifu_icache #(.ADDR_W(32), .DATA_W(32), .SETS(SETS), .WAYS(WAYS), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .perf_hit_o(perf_hit), .perf_miss_o(perf_miss)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc = '0;
  bit          exp_miss = 1'b0;
  logic [31:0] last_ar = '0;
  logic [31:0] last_inst = '0;

  logic [31:0] m_line [SETS][WAYS];
  bit          m_v    [SETS][WAYS];
  int          m_rr   [SETS];
  int          m_hits, m_misses;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'h0, act}, {31'h0, exp});
  endtask

  function automatic int set_of(input logic [31:0] a);
    return int'((a / (LW * 4)) % SETS);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int s;
    s = set_of(a);
    for (int w = 0; w < WAYS; w++)
      if (m_v[s][w] && m_line[s][w] == (a & ~32'hF)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) m_v[s][w] = 1'b0;
  endtask

  task automatic model_reset();
    model_clear();
    for (int s = 0; s < SETS; s++) m_rr[s] = 0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic model_fill(input logic [31:0] a, input bit flushed);
    int s;
    int w;
    s = set_of(a);
    w = m_rr[s];
    if (flushed) model_clear();
    m_line[s][w] = a & ~32'hF;
    m_v[s][w]    = !flushed;
    m_rr[s]      = (w + 1) % WAYS;
  endtask

  task automatic bus_idle();
    bus.prev_valid  = 1'b0;
    bus.next_ready  = 1'b0;
    bus.flush_i     = 1'b0;
    bus.ifu_arready = 1'b0;
    bus.ifu_rvalid  = 1'b0;
    bus.ifu_rlast   = 1'b0;
    bus.ifu_rdata   = '0;
  endtask

  task automatic recover_reset();
    bus_idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Per-cycle compare: delivered pc/inst and any refill request must match the model.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (bus.valid_o === 1'b1) begin
        chk("mon_pc", bus.pc_o, exp_pc);
        chk("mon_inst", bus.inst_o, mem_word(exp_pc));
      end
      if (bus.ifu_arvalid_o === 1'b1) begin
        chk("mon_araddr", bus.ifu_araddr_o, exp_pc & ~32'hF);
        chk("mon_arlen", {24'h0, bus.ifu_arlen_o}, 32'(LW - 1));
        chk1("mon_ar_expected", exp_miss, 1'b1);
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input bit lit_miss, input bit flush_mid, input int stall);
    bit model_miss;
    bit saw_ar;
    int n;
    model_miss = !model_hit(a);
    chk1("model_vs_vector", model_miss, lit_miss);
    if (model_miss) m_misses++; else m_hits++;
    exp_pc   = a;
    exp_miss = model_miss;
    n = 0;
    while (bus.ready_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk1("ready_before_fetch", bus.ready_o, 1'b1);
    bus.prev_valid = 1'b1;
    bus.npc        = a;
    @(negedge clk);
    bus.prev_valid = 1'b0;
    bus.npc        = $urandom;
    chk1("lookup_valid_low", bus.valid_o, 1'b0);
    @(negedge clk);
    saw_ar = bus.ifu_arvalid_o;
    chk1("miss_observed", saw_ar, lit_miss);
    if (saw_ar) begin
      last_ar = bus.ifu_araddr_o;
      @(negedge clk);
      chk1("arvalid_held", bus.ifu_arvalid_o, 1'b1);
      chk("araddr_held", bus.ifu_araddr_o, last_ar);
      bus.ifu_arready = 1'b1;
      @(negedge clk);
      bus.ifu_arready = 1'b0;
      for (int b = 0; b < LW; b++) begin
        bus.ifu_rvalid = 1'b1;
        bus.ifu_rdata  = mem_word((a & ~32'hF) + 32'(4 * b));
        bus.ifu_rlast  = (b == LW - 1);
        bus.flush_i    = flush_mid && (b == 1);
        @(negedge clk);
        bus.ifu_rvalid = 1'b0;
        bus.ifu_rlast  = 1'b0;
        bus.flush_i    = 1'b0;
        bus.ifu_rdata  = $urandom;
        if (b == 1) @(negedge clk);
      end
      model_fill(a, flush_mid);
    end else begin
      chk1("hit_latency", bus.valid_o, 1'b1);
    end
    n = 0;
    while (bus.valid_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk1("valid_seen", bus.valid_o, 1'b1);
    if (bus.valid_o !== 1'b1) begin
      recover_reset();
      return;
    end
    last_inst = bus.inst_o;
    chk("pc_o", bus.pc_o, a);
    chk("inst_o", bus.inst_o, mem_word(a));
    for (int i = 0; i < stall; i++) @(negedge clk);
    if (stall > 0) begin
      chk1("stall_valid", bus.valid_o, 1'b1);
      chk("stall_pc", bus.pc_o, a);
      chk("stall_inst", bus.inst_o, last_inst);
    end
    bus.next_ready = 1'b1;
    @(negedge clk);
    bus.next_ready = 1'b0;
    chk1("valid_drop", bus.valid_o, 1'b0);
    chk1("ready_back", bus.ready_o, 1'b1);
    $display("fetch pc=0x%08h miss=%0d flush_mid=%0d stall=%0d inst=0x%08h", a, saw_ar, flush_mid, stall, last_inst);
  endtask

  task automatic chk_perf(input string name, input int hits, input int misses);
`ifdef YSYX_ICACHE_PERF_EN
    chk({name, "_hit"}, perf_hit, 32'(hits));
    chk({name, "_miss"}, perf_miss, 32'(misses));
`else
    chk({name, "_hit"}, perf_hit, 32'(hits * 0));
    chk({name, "_miss"}, perf_miss, 32'(misses * 0));
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus_idle();
    bus.npc = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk1("rst_ready", bus.ready_o, 1'b1);
    chk1("rst_valid", bus.valid_o, 1'b0);
    chk1("rst_arvalid", bus.ifu_arvalid_o, 1'b0);
    chk("rst_inst", bus.inst_o, 32'h0);
    chk("rst_pc", bus.pc_o, 32'h0);
    chk_perf("rst_perf", 0, 0);
    rst = 1'b0;
    @(negedge clk);

    // Cold miss, then hit in the same line.
    fetch(32'h8000_0000, 1'b1, 1'b0, 0);
    chk("s1_araddr", last_ar, 32'h8000_0000);
    chk("s1_arlen", {24'h0, bus.ifu_arlen_o}, 32'd3);
    chk("s1_inst", last_inst, 32'h25A5_FFFF);
    fetch(32'h8000_0008, 1'b0, 1'b0, 0);
    chk("s2_inst", last_inst, 32'h25A5_FFF7);
    chk_perf("s6_perf", 1, 1);

    // Round-robin replacement within set 0.
    fetch(32'h8000_0000, 1'b0, 1'b0, 0);
    fetch(32'h8000_0100, 1'b1, 1'b0, 0);
    fetch(32'h8000_0200, 1'b1, 1'b0, 0);
    fetch(32'h8000_0100, 1'b0, 1'b0, 0);
    fetch(32'h8000_0000, 1'b1, 1'b0, 0);

    // fence.i flush, standalone and during a refill.
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    model_clear();
    $display("flush pulse");
    fetch(32'h8000_0008, 1'b1, 1'b0, 0);
    chk("s4_araddr", last_ar, 32'h8000_0000);
    fetch(32'h8000_0008, 1'b0, 1'b0, 0);
    fetch(32'h8000_0040, 1'b1, 1'b1, 0);
    fetch(32'h8000_0044, 1'b1, 1'b0, 0);
    fetch(32'h8000_0008, 1'b1, 1'b0, 0);
    fetch(32'h8000_004C, 1'b0, 1'b0, 0);

    // Last set / last word of a line.
    fetch(32'h8000_00FC, 1'b1, 1'b0, 0);
    chk("s_last_araddr", last_ar, 32'h8000_00F0);
    fetch(32'h8000_00F0, 1'b0, 1'b0, 0);

    // Downstream stall in VALID.
    fetch(32'h8000_0048, 1'b0, 1'b0, 5);
    chk_perf("mid_perf", m_hits, m_misses);

    // Reset in the middle of a refill; trailing beats must be ignored.
    exp_pc   = 32'h8000_0300;
    exp_miss = 1'b1;
    bus.prev_valid = 1'b1;
    bus.npc        = 32'h8000_0300;
    @(negedge clk);
    bus.prev_valid = 1'b0;
    @(negedge clk);
    chk1("r_arvalid", bus.ifu_arvalid_o, 1'b1);
    bus.ifu_arready = 1'b1;
    @(negedge clk);
    bus.ifu_arready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus.ifu_rvalid = 1'b1;
      bus.ifu_rdata  = mem_word(32'h8000_0300 + 32'(4 * b));
      @(negedge clk);
    end
    rst = 1'b1;
    bus.ifu_rdata = mem_word(32'h8000_0308);
    @(negedge clk);
    rst = 1'b0;
    chk1("r_ready", bus.ready_o, 1'b1);
    chk1("r_valid", bus.valid_o, 1'b0);
    chk1("r_arvalid_low", bus.ifu_arvalid_o, 1'b0);
    chk("r_inst", bus.inst_o, 32'h0);
    chk("r_pc", bus.pc_o, 32'h0);
    chk_perf("r_perf", 0, 0);
    bus.ifu_rdata = mem_word(32'h8000_030C);
    bus.ifu_rlast = 1'b1;
    @(negedge clk);
    bus.ifu_rvalid = 1'b0;
    bus.ifu_rlast  = 1'b0;
    @(negedge clk);
    chk1("r_stray_valid", bus.valid_o, 1'b0);
    chk1("r_stray_ready", bus.ready_o, 1'b1);
    model_reset();
    $display("reset mid-refill pc=0x80000300");

    fetch(32'h8000_0300, 1'b1, 1'b0, 0);
    fetch(32'h8000_0044, 1'b1, 1'b0, 0);
    fetch(32'h8000_0304, 1'b0, 1'b0, 0);
    chk_perf("end_perf", m_hits, m_misses);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
